// File: rtl/sys_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sys_rst_pkg                                                       |
// | Purpose : Shared definitions for the system restart scheduler: FSM state    |
// |           encodings, request source indices and a saturating increment.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package sys_rst_pkg;

   // Scheduler states; the encoding is exported on SCHED_STATE for debug.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_PULSE   = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_HOLD    = 3'd5
   } sched_state_t;

   // Request source indices; bit 0 has the highest priority.
   localparam int c_src_jtag = 0;
   localparam int c_src_csp  = 1;
   localparam int c_src_qpll = 2;
   localparam int c_src_mmcm = 3;

   // Width of the shared state timer; large enough for the wait timeout.
   localparam int c_tmr_w = 20;

   // Increment that sticks at max_val instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rst_req_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rst_req_capture                                                   |
// | Purpose : Registers the restart request levels, detects unmasked rising    |
// |           edges and keeps one pending bit per source.                      |
// | Ports   : clk, rst_n   clock / asynchronous active-low reset               |
// |           i_req        request levels (N)                                   |
// |           i_mask       1 = ignore that source's edges (N)                   |
// |           i_clr        clear all pending bits (arbitration strobe)          |
// |           o_pending    pending request bits (N)                             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rst_req_capture
   import sys_rst_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_mask,
   input  logic         i_clr,
   output logic [N-1:0] o_pending
);

   logic [N-1:0] r_req;
   logic [N-1:0] r_req_q;
   logic [N-1:0] r_pending;
   logic [N-1:0] w_rise;

   // Edge detect runs on the registered copy so that the request path is
   // one flop deep before it can influence the pending bits.
   assign w_rise = r_req & ~r_req_q & ~i_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req     <= '0;
         r_req_q   <= '0;
         r_pending <= '0;
      end else begin
         r_req     <= i_req;
         r_req_q   <= r_req;
         // A new edge in the clearing cycle survives: set beats clear.
         r_pending <= (i_clr ? '0 : r_pending) | w_rise;
      end
   end

   assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/sys_rst_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sys_rst_scheduler                                                 |
// | Purpose : Arbitrates restart requests into a single RESTART pulse,         |
// |           supervises the RUN drop/return with a timeout, enforces a        |
// |           holdoff against restart storms and keeps cause/statistics.       |
// | Ports   : CLK          system clock                                         |
// |           EOS          asynchronous active-low reset                        |
// |           REQ          restart request levels (N_SRC)                       |
// |           REQ_MASK     1 = ignore that source (N_SRC)                       |
// |           RUN          run status from the reset manager                    |
// |           CLR_STAT     clear RST_CNT / TMO_ERR / CAUSE_VLD (/ SRC_CNT)      |
// |           RESTART      restart pulse, PULSE_W cycles                        |
// |           BUSY         scheduler not idle                                   |
// |           CAUSE        pending bits captured at the last arbitration        |
// |           CAUSE_VLD    CAUSE holds a valid record                           |
// |           TMO_ERR      sticky wait timeout flag                             |
// |           RST_CNT      saturating count of issued pulses                    |
// |           SRC_CNT      per-source saturating counts                         |
// |           SCHED_STATE  FSM state for debug                                  |
// | Macro   : SYS_RST_SRC_STATS_EN enables the per-source counters; without   |
// |           it SRC_CNT is tied to zero.                                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sys_rst_scheduler
   import sys_rst_pkg::*;
#(
   parameter int          N_SRC    = 4,
   parameter int          PULSE_W  = 8,
   parameter logic [15:0] HOLDOFF  = 16'd40000,
   parameter logic [19:0] DONE_TMO = 20'd400000,
   parameter int          CNT_W    = 8
) (
   input  logic                   CLK,
   input  logic                   EOS,
   input  logic [N_SRC-1:0]       REQ,
   input  logic [N_SRC-1:0]       REQ_MASK,
   input  logic                   RUN,
   input  logic                   CLR_STAT,
   output logic                   RESTART,
   output logic                   BUSY,
   output logic [N_SRC-1:0]       CAUSE,
   output logic                   CAUSE_VLD,
   output logic                   TMO_ERR,
   output logic [CNT_W-1:0]       RST_CNT,
   output logic [N_SRC*CNT_W-1:0] SRC_CNT,
   output logic [2:0]             SCHED_STATE
);

   localparam logic [31:0]        c_cnt_max   = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [c_tmr_w-1:0] c_pulse_last = c_tmr_w'(PULSE_W - 1);
   localparam logic [c_tmr_w-1:0] c_hold_last  = c_tmr_w'(HOLDOFF) - 1'b1;
   localparam logic [c_tmr_w-1:0] c_tmo_last   = c_tmr_w'(DONE_TMO) - 1'b1;

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic                w_tmr_clr;
   logic                w_tmo_set;
   logic [c_tmr_w-1:0]  r_tmr;
   logic [N_SRC-1:0]    w_pending;
   logic                w_arb;
   logic                r_restart;
   logic                r_run_lo_seen;
   logic [N_SRC-1:0]    r_cause;
   logic                r_cause_vld;
   logic                r_tmo_err;
   logic [CNT_W-1:0]    r_rst_cnt;

   assign w_arb = (r_state == ST_ARB);

   rst_req_capture #(
      .N (N_SRC)
   ) u_capture (
      .clk       (CLK),
      .rst_n     (EOS),
      .i_req     (REQ),
      .i_mask    (REQ_MASK),
      .i_clr     (w_arb),
      .o_pending (w_pending)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge EOS) begin
      if (!EOS) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_clr   = 1'b0;
      w_tmo_set   = 1'b0;
      case (r_state)
         ST_IDLE:    if (|w_pending) w_state_nxt = ST_ARB;
         ST_ARB:     w_state_nxt = ST_PULSE;
         ST_PULSE:   if (r_tmr == c_pulse_last) w_state_nxt = ST_WAIT_LO;
         ST_WAIT_LO: begin
            // RUN may already have dropped while the pulse was still high.
            if (!RUN || r_run_lo_seen) begin
               w_state_nxt = ST_WAIT_HI;
            end else if (r_tmr > c_tmo_last) begin
               w_state_nxt = ST_HOLD;
               w_tmo_set   = 1'b1;
            end
         end
         ST_WAIT_HI: begin
            if (RUN) begin
               w_state_nxt = ST_HOLD;
            end else if (r_tmr > c_tmo_last) begin
               w_state_nxt = ST_HOLD;
               w_tmo_set   = 1'b1;
            end
         end
         ST_HOLD: begin
            // A RUN drop means the system is not yet stable: start over.
            if (!RUN)                     w_tmr_clr   = 1'b1;
            else if (r_tmr == c_hold_last) w_state_nxt = ST_IDLE;
         end
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Shared timer: zero on every state entry, sticks at all-ones.
   always_ff @(posedge CLK or negedge EOS) begin
      if (!EOS) begin
         r_tmr <= '0;
      end else if ((w_state_nxt != r_state) || w_tmr_clr) begin
         r_tmr <= '0;
      end else if (r_tmr != '1) begin
         r_tmr <= r_tmr + 1'b1;
      end
   end

   // RESTART comes straight from a flop so the reset manager sees no glitches.
   always_ff @(posedge CLK or negedge EOS) begin
      if (!EOS) begin
         r_restart     <= 1'b0;
         r_run_lo_seen <= 1'b0;
      end else begin
         r_restart <= (w_state_nxt == ST_PULSE);
         if (w_arb)                             r_run_lo_seen <= 1'b0;
         else if ((r_state == ST_PULSE) && !RUN) r_run_lo_seen <= 1'b1;
      end
   end

   // ---------------------------------------------------------- statistics
   // An arbitration in the same cycle as CLR_STAT still records itself,
   // so the counter restarts at one rather than zero.
   always_ff @(posedge CLK or negedge EOS) begin
      if (!EOS) begin
         r_cause     <= '0;
         r_cause_vld <= 1'b0;
         r_rst_cnt   <= '0;
         r_tmo_err   <= 1'b0;
      end else begin
         if (w_arb) begin
            r_cause     <= w_pending;
            r_cause_vld <= 1'b1;
            r_rst_cnt   <= CLR_STAT ? CNT_W'(1)
                                    : CNT_W'(sat_inc(32'(r_rst_cnt), c_cnt_max));
         end else if (CLR_STAT) begin
            r_cause_vld <= 1'b0;
            r_rst_cnt   <= '0;
         end
         if (w_tmo_set)     r_tmo_err <= 1'b1;
         else if (CLR_STAT) r_tmo_err <= 1'b0;
      end
   end

`ifdef SYS_RST_SRC_STATS_EN
   logic [CNT_W-1:0] r_src_cnt [N_SRC];

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_cnt
      always_ff @(posedge CLK or negedge EOS) begin
         if (!EOS) begin
            r_src_cnt[gi] <= '0;
         end else if (w_arb) begin
            if (CLR_STAT)
               r_src_cnt[gi] <= CNT_W'(w_pending[gi]);
            else if (w_pending[gi])
               r_src_cnt[gi] <= CNT_W'(sat_inc(32'(r_src_cnt[gi]), c_cnt_max));
         end else if (CLR_STAT) begin
            r_src_cnt[gi] <= '0;
         end
      end
      assign SRC_CNT[gi*CNT_W +: CNT_W] = r_src_cnt[gi];
   end
`else
   assign SRC_CNT = '0;
`endif

   assign RESTART     = r_restart;
   assign BUSY        = (r_state != ST_IDLE);
   assign CAUSE       = r_cause;
   assign CAUSE_VLD   = r_cause_vld;
   assign TMO_ERR     = r_tmo_err;
   assign RST_CNT     = r_rst_cnt;
   assign SCHED_STATE = r_state;

endmodule
`default_nettype wire

// File: doc/sys_rst_scheduler.md
Name: sys_rst_scheduler

Overview:
- Arbitrates system-restart requests from several sources (JTAG, CSP, QPLL lock loss, MMCM unlock, ...).
- Turns them into one well-formed RESTART pulse that drives the reset manager's restart input.
- Supervises the recovery: waits for RUN to drop and then return, with a timeout.
- Enforces a holdoff so a flapping source cannot cause a restart storm; latches cause and statistics for slow control.

Parameters:
- N_SRC, 4, number of request sources; bit 0 is highest priority.
- PULSE_W, 8, RESTART pulse width in CLK cycles (min 1).
- HOLDOFF, 16'd40000, minimum cycles from RUN re-assertion to the next RESTART (1 ms at 40 MHz).
- DONE_TMO, 20'd400000, max cycles allowed in each wait state (10 ms).
- CNT_W, 8, width of the restart counters.

Ports:
- CLK  in  1  40 MHz system clock.
- EOS  in  1  asynchronous active-low reset (End Of Startup); all state clears while low.
- REQ  in  N_SRC  restart requests, level, synchronous to CLK; rising edge = one request.
- REQ_MASK  in  N_SRC  1 = ignore that source's edges.
- RUN  in  1  system run status returned by the reset manager.
- CLR_STAT  in  1  one-cycle pulse: clear RST_CNT, TMO_ERR, CAUSE_VLD.
- RESTART  out  1  restart pulse to the reset manager.
- BUSY  out  1  high in any state other than IDLE.
- CAUSE  out  N_SRC  pending bits captured at the last arbitration.
- CAUSE_VLD  out  1  CAUSE holds a valid record.
- TMO_ERR  out  1  sticky; a wait state timed out.
- RST_CNT  out  CNT_W  saturating count of RESTART pulses issued.
- SRC_CNT  out  N_SRC*CNT_W  per-source saturating counts (optional feature).
- SCHED_STATE  out  3  state encoding for debug.

Behaviour:
- Reset values: RESTART=0, BUSY=0, CAUSE=0, CAUSE_VLD=0, TMO_ERR=0, RST_CNT=0, SRC_CNT=0, SCHED_STATE=IDLE(0), pending=0, all timers=0.
- Request capture:
  - REQ is registered once; rise = REQ & ~REQ_q & ~REQ_MASK.
  - rise sets pending[i] in every state.
  - Clearing pending at ARB: the set takes priority over the clear when both hit the same bit in the same cycle.
- FSM encoding: IDLE=0, ARB=1, PULSE=2, WAIT_LO=3, WAIT_HI=4, HOLD=5.
- IDLE: if pending!=0, go to ARB on the next cycle.
- ARB (1 cycle):
  - CAUSE<=pending; CAUSE_VLD<=1; pending<=0, except bits rising this cycle.
  - RST_CNT += 1, saturating at all-ones.
  - Go to PULSE.
- PULSE: RESTART=1 for exactly PULSE_W cycles, registered output; then go to WAIT_LO.
- WAIT_LO: wait for RUN=0.
  - A RUN low already sampled during PULSE counts.
  - Timer > DONE_TMO-1: set TMO_ERR, go to HOLD.
- WAIT_HI: on RUN=1 go to HOLD; on timeout set TMO_ERR and go to HOLD.
- HOLD: count HOLDOFF cycles, then go to IDLE.
  - If RUN falls during HOLD: restart the holdoff count (system not stable).
- Timer rule: one shared timer, cleared on every state entry; it saturates and does not wrap.
- Latency: REQ rise to RESTART high = 4 CLK cycles (input reg, pending, IDLE->ARB, ARB->PULSE).
- New requests during PULSE/WAIT/HOLD are held pending and serviced only after HOLD completes. Repeated edges of the same source merge into one.
- CLR_STAT in the same cycle as ARB: the ARB update wins for CAUSE/CAUSE_VLD/RST_CNT (counter becomes 1); TMO_ERR is still cleared.
- EOS low mid-pulse drops RESTART immediately (asynchronous); requests seen before reset are lost.

Optional Feature:
- Macro: SYS_RST_SRC_STATS_EN.
- Defined:
  - SRC_CNT slice i increments, saturating, at ARB for each CAUSE bit i set.
  - Cleared by CLR_STAT with the same ARB-wins rule.
- Undefined: SRC_CNT tied to 0; no counter logic is synthesised.

Decomposition:
- Shared package (sys_rst_pkg):
  - state encodings;
  - source index constants (SRC_JTAG=0, SRC_CSP=1, SRC_QPLL=2, SRC_MMCM=3);
  - a saturating-increment function.
- One natural sub-module: rst_req_capture (edge detect, mask, pending set/clear with set priority), instantiated once with width N_SRC.

Test Plan:
1. Reset then single request:
   - EOS low, release; REQ[1] rise.
   - Expect: RESTART high at cycle +4 for 8 cycles; CAUSE=4'b0010, CAUSE_VLD=1, RST_CNT=1.
   - Model RUN low 3 cycles after RESTART and high 100 cycles later; expect BUSY low exactly HOLDOFF cycles after RUN rises.
2. Simultaneous and masked requests:
   - REQ[0] and REQ[3] rise in the same cycle, REQ_MASK=4'b1000.
   - Expect CAUSE=4'b0001, one pulse only, pending[3]=0.
3. Request during HOLD:
   - REQ[2] rises 10 cycles into HOLD.
   - Expect no RESTART until HOLD ends, then a second pulse; RST_CNT=2, CAUSE=4'b0100.
4. Timeout:
   - RUN held at 1 throughout.
   - Expect TMO_ERR=1 after DONE_TMO cycles in WAIT_LO, then HOLD, then IDLE; CLR_STAT clears TMO_ERR.
5. Reset mid-pulse:
   - EOS low at pulse cycle 3.
   - Expect RESTART=0 asynchronously and all outputs at reset values; no pulse after EOS returns high unless REQ rises again.
6. Saturation (with SYS_RST_SRC_STATS_EN): 260 REQ[0] events.
   - Expect RST_CNT=255 and SRC_CNT[7:0]=255.
   - Rebuild without the macro: SRC_CNT=0.
